// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch unit. Holds the program counter (word address), drives
//   it straight onto the instruction memory read port, and captures the
//   combinationally returned word together with its PC into a single output
//   register stage guarded by a valid/ready handshake. Execute can redirect
//   fetch at any time. Fetching a SYSTEM-opcode word delivers that word and
//   then parks the unit in HALT until a redirect or reset.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   o_mem_addr       word address to instruction memory (= PC)
//   i_mem_data       instruction word for o_mem_addr (combinational)
//   o_inst_valid     output stage holds an instruction
//   i_inst_ready     decode accepts the instruction this cycle
//   o_inst           held instruction word
//   o_inst_pc        word address of o_inst
//   i_redirect       flush and restart fetch at i_redirect_addr
//   i_redirect_addr  redirect target word address
//   o_halted         unit is in HALT
//   o_fetch_count    number of completed handshakes (wraps)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR    = 32'd0,
  parameter logic [6:0]  SYSTEM_OPCODE = 7'b1110011
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_halted,
  output logic [31:0] o_fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_halted;
  logic [31:0] r_fetch_count;

  logic        w_fire;
  logic        w_free;
  logic        w_is_system;

  assign w_fire      = r_inst_valid & i_inst_ready;
  // The stage can take a new word when empty or when its current word
  // leaves this same cycle, so backpressure release costs no bubble.
  assign w_free      = ~r_inst_valid | w_fire;
  assign w_is_system = (i_mem_data[6:0] == SYSTEM_OPCODE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_ADDR;
      r_inst        <= 32'd0;
      r_inst_pc     <= 32'd0;
      r_inst_valid  <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      // A handshake completes regardless of any redirect in the same cycle.
      if (w_fire) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      if (i_redirect) begin
        r_inst_valid <= 1'b0;
        r_pc         <= i_redirect_addr;
        r_state      <= S_RUN;
        r_halted     <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_free) begin
              r_inst       <= i_mem_data;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              // PC stays on the SYSTEM word so o_mem_addr points at it
              // while halted.
              if (w_is_system) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc <= r_pc + 32'd1;
              end
            end
          end
          S_HALT: begin
            if (w_fire) begin
              r_inst_valid <= 1'b0;
            end
          end
          default: begin
            r_state <= S_RUN;
          end
        endcase
      end
    end
  end

  assign o_mem_addr    = r_pc;
  assign o_inst_valid  = r_inst_valid;
  assign o_inst        = r_inst;
  assign o_inst_pc     = r_inst_pc;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that drives the instruction memory's read port and delivers fetched words to decode. Holds the program counter as a word address, issues one combinational read per cycle, registers the returned word with its PC into a one-entry output stage under a valid/ready handshake, and accepts redirects from execute. On fetching a SYSTEM-opcode instruction it delivers that instruction, then halts until redirected or reset.

## Interface
- RESET_ADDR, 0: word address loaded into PC on reset
- SYSTEM_OPCODE, 7'b1110011: opcode field (bits [6:0]) that triggers halt
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- o_mem_addr  output  32  word address to instruction memory read port (= PC)
- i_mem_data  input  32  instruction word returned combinationally for o_mem_addr
- o_inst_valid  output  1  output stage holds an instruction
- i_inst_ready  input  1  decode accepts the instruction this cycle
- o_inst  output  32  held instruction word
- o_inst_pc  output  32  word address of o_inst
- i_redirect  input  1  flush and restart fetch at i_redirect_addr
- i_redirect_addr  input  32  redirect target, word address
- o_halted  output  1  unit is in HALT state
- o_fetch_count  output  32  count of completed handshakes (valid & ready)

## Operation
- States: RUN, HALT. Reset -> RUN.
- Reset values: PC = RESET_ADDR, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0, o_halted = 0, o_fetch_count = 0.
- o_mem_addr is PC directly; no registering on the memory side.
- Handshake "fire" = o_inst_valid & i_inst_ready. Output stage is "free" when !o_inst_valid or fire.
- Priority per cycle: reset > redirect > capture > hold.
- Redirect (any state): o_inst_valid <= 0, PC <= i_redirect_addr, state <= RUN. No capture that cycle. If fire occurs in the same cycle, o_fetch_count still increments.
- RUN, no redirect, stage free: o_inst <= i_mem_data, o_inst_pc <= PC, o_inst_valid <= 1, PC <= PC + 1. If i_mem_data[6:0] == SYSTEM_OPCODE: state <= HALT, PC unchanged (not incremented).
- RUN, stage not free: hold all of o_inst/o_inst_pc/o_inst_valid/PC.
- HALT, no redirect: no capture, PC held; on fire, o_inst_valid <= 0. o_halted = 1 while in HALT.
- o_fetch_count increments by 1 on every fire, wraps modulo 2^32; cleared only by reset.
- PC + 1 wraps modulo 2^32 (0xFFFFFFFF -> 0).
- Out-of-range addresses: memory returns 0; 0 is captured as an ordinary instruction (opcode 0, no halt).

## Timing
- Memory read is combinational: instruction at PC is captured on the same edge that advances PC.
- Latency: first instruction valid 1 cycle after reset deasserts; 1 cycle from redirect to first valid at the new target.
- Throughput: 1 instruction/cycle while i_inst_ready held high.
- Stall: with i_inst_ready low, outputs stable indefinitely; backpressure costs no bubbles on release.
- Halt: state and o_halted update on the edge that captures the SYSTEM instruction; that instruction remains valid until consumed.
- Reset asserted mid-operation returns all state to reset values on the next edge regardless of handshake or redirect.

## Test plan
- Reset, i_inst_ready=1, memory program 00A00593,00000613,00000693,00100713,00E687B3,00070693,00078713,00160613,FEB618E3,00070073 -> o_inst sequence matches on consecutive cycles with o_inst_pc 0..9, o_halted=1 after word 9, o_inst_valid drops next cycle, o_fetch_count=10, o_mem_addr stays 9.
- Backpressure: i_inst_ready=0 for cycles 2-5 after reset -> o_inst=00000613, o_inst_pc=1 held stable, PC=2 held; release -> 00000693 next cycle, no duplicate or dropped word.
- Redirect while valid: at pc 4 assert i_redirect, addr=1 -> next cycle o_inst_valid=0; following cycle o_inst=00000613, o_inst_pc=1.
- Redirect from HALT to address 0 -> o_halted=0, o_inst=00A00593 one cycle later; simultaneous fire increments o_fetch_count once.
- Wrap: redirect to 0xFFFFFFFF (memory returns 0) -> o_inst_pc=0xFFFFFFFF then 0x00000000, o_inst=0 then 00A00593.
- Reset mid-stall with valid=1 and in HALT -> all outputs at reset values next edge, o_fetch_count=0, fetch restarts at RESET_ADDR.
